fetch_s: RTL and testbench

Instruction fetch stage directly upstream of the `rom_s` instruction ROM. It owns the program counter and drives the ROM word address. It captures the ROM's registered instruction one cycle later and presents a (pc, instr) stream to decode through a valid/ready handshake. A 2-entry output buffer decouples decode back-pressure from the ROM. Branch/jump redirects flush everything in flight.

---
 rtl/fetch_s.sv | 128 ++++++++++++
 tb/tb_fetch_s.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_s.sv
// Instruction fetch stage: owns the PC, drives the ROM word address and feeds decode
// through a 2-entry {pc, instr} buffer. A redirect flushes everything in flight.
module fetch_s #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_instr,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_instr,
  output logic              misalign_err
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        inflight_q, inflight_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] e0_pc_q, e0_pc_d, e0_in_q, e0_in_d;
  logic [31:0] e1_pc_q, e1_pc_d, e1_in_q, e1_in_d;
  logic        mis_q, mis_d;
  logic        pop, push, issue;
  logic [2:0]  credit;

  always_comb begin
    pop    = (count_q != 2'd0) & if_ready;
    push   = inflight_q & ~redirect_valid;
    // Entries that will be occupied next cycle; issuing only when at most one
    // is used guarantees the response always finds a free slot.
    credit = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue  = fetch_en & ~redirect_valid & (credit <= 3'd1);

    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    count_d    = count_q;
    e0_pc_d    = e0_pc_q;
    e0_in_d    = e0_in_q;
    e1_pc_d    = e1_pc_q;
    e1_in_d    = e1_in_q;
    mis_d      = 1'b0;

    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      count_d = 2'd0;
      mis_d   = |redirect_pc[1:0];
    end else begin
      inflight_d = issue;
      if (issue) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + 32'd4;
      end
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            e0_pc_d = req_pc_q;
            e0_in_d = rom_instr;
            count_d = 2'd1;
          end else if (count_q == 2'd1) begin
            e1_pc_d = req_pc_q;
            e1_in_d = rom_instr;
            count_d = 2'd2;
          end
        end
        2'b01: begin
          if (count_q == 2'd2) begin
            e0_pc_d = e1_pc_q;
            e0_in_d = e1_in_q;
          end
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            e0_pc_d = req_pc_q;
            e0_in_d = rom_instr;
          end else begin
            e0_pc_d = e1_pc_q;
            e0_in_d = e1_in_q;
            e1_pc_d = req_pc_q;
            e1_in_d = rom_instr;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= 32'd0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      e0_pc_q    <= 32'd0;
      e0_in_q    <= 32'd0;
      e1_pc_q    <= 32'd0;
      e1_in_q    <= 32'd0;
      mis_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      e0_pc_q    <= e0_pc_d;
      e0_in_q    <= e0_in_d;
      e1_pc_q    <= e1_pc_d;
      e1_in_q    <= e1_in_d;
      mis_q      <= mis_d;
    end
  end

  assign rom_addr     = pc_q[ADDR_W+1:2];
  assign if_valid     = (count_q != 2'd0);
  assign if_pc        = e0_pc_q;
  assign if_instr     = e0_in_q;
  assign misalign_err = mis_q;

  // A response arriving at a full buffer with no pop would be silently lost.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count_q == 2'd2));

endmodule

// File: tb/tb_fetch_s.sv
// Bench for fetch_s: directed scenarios followed by randomized traffic, all checked
// against a program-order PC model and a ROM whose word k holds 0x1000_0000 + k.
module tb_fetch_s;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n, fetch_en, redirect_valid, if_ready;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_instr = 32'd0;
  logic [31:0]       redirect_pc, if_pc, if_instr;
  logic              if_valid, misalign_err;

  fetch_s #(.RESET_PC(32'h0), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .rom_addr(rom_addr),
    .rom_instr(rom_instr), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .misalign_err(misalign_err));

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return 32'h1000_0000 + {22'd0, pc[11:2]};
  endfunction

  always @(posedge clk) rom_instr <= rom_word({20'd0, rom_addr, 2'b00});

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: the stream decode accepts must be contiguous PCs from the last
  // reset/redirect target, each carrying ROM[pc>>2].
  logic [31:0] exp_pc = 32'h0, hold_pc = 32'h0, hold_instr = 32'h0;
  logic        exp_mis = 1'b0, hold = 1'b0;
  int          blank = 0, good_run = 0, accepted = 0;

  task automatic monitor();
    if (!rst_n) begin
      exp_pc = 32'h0; exp_mis = 1'b0; hold = 1'b0; blank = 2; good_run = 0;
      return;
    end
    chk("misalign", 32'(misalign_err), 32'(exp_mis));
    if (blank > 0) begin
      chk("flush_valid", 32'(if_valid), 32'd0);
      blank--;
    end
    if (hold) begin
      chk("stable_valid", 32'(if_valid), 32'd1);
      chk("stable_pc", if_pc, hold_pc);
      chk("stable_instr", if_instr, hold_instr);
    end
    if (good_run >= 2 && fetch_en && if_ready && !redirect_valid)
      chk("live_valid", 32'(if_valid), 32'd1);
    if (if_valid && if_ready && !redirect_valid) begin
      chk("order_pc", if_pc, exp_pc);
      chk("order_instr", if_instr, rom_word(exp_pc));
      exp_pc += 32'd4;
      accepted++;
    end
    hold       = if_valid && !if_ready && !redirect_valid;
    hold_pc    = if_pc;
    hold_instr = if_instr;
    if (redirect_valid) begin
      exp_pc  = {redirect_pc[31:2], 2'b00};
      exp_mis = |redirect_pc[1:0];
      blank   = 2;
    end else begin
      exp_mis = 1'b0;
    end
    if (fetch_en && if_ready && !redirect_valid) good_run++;
    else good_run = 0;
  endtask

  task automatic sample();
    @(negedge clk);
    monitor();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic restart_check(input string tag);
    sample(); chk({tag, "_c0_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_c0_pc"}, if_pc, 32'd0);
    chk({tag, "_c0_addr"}, 32'(rom_addr), 32'd0); adv();
    sample(); chk({tag, "_c1_valid"}, 32'(if_valid), 32'd0); adv();
    for (int i = 0; i < 3; i++) begin
      sample();
      chk({tag, "_valid"}, 32'(if_valid), 32'd1);
      chk({tag, "_pc"}, if_pc, 32'(4 * i));
      chk({tag, "_instr"}, if_instr, 32'h1000_0000 + 32'(i));
      adv();
    end
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b1; if_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    adv(); adv();
    sample();
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_mis", 32'(misalign_err), 32'd0);
    adv();

    // Reset release: cycles 0..4
    rst_n = 1'b1;
    restart_check("boot");

    // Decode stall from what would be cycle 5 onward; head must hold, issue stops.
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("stall_pc", if_pc, 32'd12);
      if (i >= 1) chk("stall_addr", 32'(rom_addr), 32'd5);
      adv();
    end
    if_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample(); chk("resume_pc", if_pc, 32'd12 + 32'(4 * i)); adv();
    end

    // Redirect with the buffer full
    if_ready = 1'b0;
    repeat (3) begin sample(); adv(); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    sample(); adv();
    redirect_valid = 1'b0; if_ready = 1'b1;
    sample(); chk("redir_t1_valid", 32'(if_valid), 32'd0);
    chk("redir_t1_addr", 32'(rom_addr), 32'h80); adv();
    sample(); chk("redir_t2_valid", 32'(if_valid), 32'd0); adv();
    sample(); chk("redir_t3_valid", 32'(if_valid), 32'd1);
    chk("redir_t3_pc", if_pc, 32'h200);
    chk("redir_t3_instr", if_instr, 32'h1000_0080); adv();

    // Misaligned redirect near the top of the ROM, then address wrap
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0FFA;
    sample(); adv();
    redirect_valid = 1'b0;
    sample(); chk("mis_t1", 32'(misalign_err), 32'd1);
    chk("mis_t1_addr", 32'(rom_addr), 32'h3FE); adv();
    sample(); chk("mis_t2", 32'(misalign_err), 32'd0); adv();
    sample(); chk("wrap_pc0", if_pc, 32'hFF8);
    chk("wrap_addr", 32'(rom_addr), 32'd0); adv();
    sample(); chk("wrap_pc1", if_pc, 32'hFFC); adv();
    sample(); chk("wrap_pc2", if_pc, 32'h1000);
    chk("wrap_instr2", if_instr, 32'h1000_0000); adv();

    // Mid-stream reset with the buffer full
    if_ready = 1'b0;
    repeat (3) begin sample(); adv(); end
    rst_n = 1'b0;
    sample(); adv();
    rst_n = 1'b1; if_ready = 1'b1;
    restart_check("mid_rst");

    // Randomized traffic
    accepted = 0;
    for (int c = 0; c < 10000; c++) begin
      logic [31:0] rp;
      rst_n          = ($urandom_range(0, 1999) != 0);
      fetch_en       = ($urandom_range(0, 9) < 8);
      if_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 31) == 0);
      rp = $urandom;
      if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
      redirect_pc = rp;
      sample();
      adv();
    end
    chk("rand_progress", 32'(accepted > 2000), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
